// File: rtl/micro2_pkg.sv
// micro2_pkg: opcodes, sequencer states, flag bit positions and helpers shared by the micro2 core.
package micro2_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned FLAG_W   = 4;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LDL   = 4'h5;
  localparam logic [3:0] OP_LDH   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_BZ    = 4'h8;
  localparam logic [3:0] OP_BNZ   = 4'h9;
  localparam logic [3:0] OP_BC    = 4'hA;
  localparam logic [3:0] OP_WAITX = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;

  // Flags are packed {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_e;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/micro2_alu.sv
// micro2_alu: combinational ADD/SUB/AND/OR (and MUL when MICRO2_MUL_EN is defined) with {N,Z,C,V}.
module micro2_alu
  import micro2_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  y_c,
  output logic [FLAG_W-1:0] flags_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef MICRO2_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
`endif

  // SUB carry means "no borrow", i.e. a >= b unsigned
  always_comb begin
    y_c   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        y_c   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y_c   = diff[WIDTH-1:0];
        carry = ~diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y_c = a & b;
      OP_OR:  y_c = a | b;
`ifdef MICRO2_MUL_EN
      OP_MUL: begin
        y_c   = prod[WIDTH-1:0];
        carry = |prod[2*WIDTH-1:WIDTH];
        ovf   = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  assign flags_c = {y_c[WIDTH-1], (y_c == '0), carry, ovf};

endmodule

// File: rtl/micro2.sv
// micro2: two-cycle fetch/execute core with program-load port, flags, relative branches, WAITX and HALT.
// Define MICRO2_MUL_EN to make opcode D an unsigned multiply; otherwise D behaves as a NOP.
module micro2
  import micro2_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned IRAM_ADDR_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IRAM_ADDR_BITS-1:0] iram_wa,
  input  logic                      iram_wen,
  input  logic [INSTR_W-1:0]        iram_din,
  input  logic                      en,
  input  logic                      run,
  input  logic                      extCtl,
  input  logic [3:0]                monRFSrc,
  output logic [WIDTH-1:0]          monRFData,
  output logic [INSTR_W-1:0]        monInstr,
  output logic [IRAM_ADDR_BITS-1:0] monPC,
  output logic [FLAG_W-1:0]         flags,
  output logic                      halted,
  output logic                      retire
);

  localparam int unsigned DEPTH = 2 ** IRAM_ADDR_BITS;

  logic [INSTR_W-1:0]        imem [DEPTH];
  logic [WIDTH-1:0]          rf   [NUM_REGS];
  state_e                    state;
  logic [IRAM_ADDR_BITS-1:0] pc;
  logic [IRAM_ADDR_BITS-1:0] pc_inc;
  logic [IRAM_ADDR_BITS-1:0] pc_rel;
  logic [INSTR_W-1:0]        instr;

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rb;
  logic [3:0]        ra;
  logic [7:0]        imm8;
  logic [WIDTH-1:0]  alu_y;
  logic [FLAG_W-1:0] alu_flags;
  logic              is_alu;
  logic              taken;

  assign op     = instr[15:12];
  assign rd     = instr[11:8];
  assign rb     = instr[7:4];
  assign ra     = instr[3:0];
  assign imm8   = instr[7:0];
  assign pc_inc = pc + IRAM_ADDR_BITS'(1);
  assign pc_rel = IRAM_ADDR_BITS'(32'(pc) + sext8(imm8));

  micro2_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (op),
    .a       (rf[ra]),
    .b       (rf[rb]),
    .y_c     (alu_y),
    .flags_c (alu_flags)
  );

  // Decode: which ops write rd/flags, and whether a branch is taken
  always_comb begin
    is_alu = 1'b0;
    taken  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu = 1'b1;
`ifdef MICRO2_MUL_EN
      OP_MUL: is_alu = 1'b1;
`endif
      OP_JMP: taken = 1'b1;
      OP_BZ:  taken = flags[FLAG_Z];
      OP_BNZ: taken = ~flags[FLAG_Z];
      OP_BC:  taken = flags[FLAG_C];
      default: ;
    endcase
  end

  // Retire marks the cycle in which an instruction completes
  always_comb begin
    retire = 1'b0;
    if (en && !reset) begin
      case (state)
        EXEC:    retire = (op != OP_WAITX) && (op != OP_HALT);
        WAIT:    retire = extCtl;
        HALT:    retire = run;
        default: retire = 1'b0;
      endcase
    end
  end

  // Program-load port runs regardless of en/reset
  always_ff @(posedge clk) begin
    if (iram_wen) imem[iram_wa] <= iram_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      instr <= '0;
      flags <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (en) begin
      case (state)
        FETCH: begin
          instr <= imem[pc];
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          pc    <= taken ? pc_rel : pc_inc;
          if (is_alu) begin
            rf[rd] <= alu_y;
            flags  <= alu_flags;
          end
          case (op)
            OP_LDL: rf[rd] <= WIDTH'(imm8);
            OP_LDH: rf[rd] <= WIDTH'({imm8, 8'h00});
            OP_WAITX: begin
              state <= WAIT;
              pc    <= pc;
            end
            OP_HALT: begin
              state <= HALT;
              pc    <= pc;
            end
            default: ;
          endcase
        end
        WAIT: begin
          if (extCtl) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        HALT: begin
          if (run) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign monRFData = rf[monRFSrc];
  assign monInstr  = instr;
  assign monPC     = pc;
  assign halted    = (state == HALT);

endmodule
